// File: rtl/lane_arb_pkg.sv
// Shared lane-arbiter definitions: lane count, lane index type, FSM encoding.
package lane_arb_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 2;

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef enum logic {
    Idle = 1'b0,
    Own  = 1'b1
  } arb_state_e;

  function automatic logic [NUM_LANES-1:0] lane_onehot(lane_idx_t idx);
    lane_onehot      = '0;
    lane_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set request bit at start, start+1, ... mod 4.
module rr_pick4
  import lane_arb_pkg::*;
(
  input  logic [3:0] req_i,
  input  logic [1:0] start_i,
  output logic       found_o,
  output logic [1:0] idx_o
);

  lane_idx_t cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    cand    = start_i;
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    for (int i = 3; i >= 0; i--) begin
      cand = start_i + 2'(i);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/lane_rr_arbiter.sv
// Four-lane burst round-robin arbiter with a single registered output slot.
// Optional LANE_MASK_EN adds a lane_enable input that masks lanes out of arbitration.
module lane_rr_arbiter
  import lane_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef LANE_MASK_EN
  input  logic [3:0]               lane_enable,
`endif
  input  logic [3:0]               in_valid,
  input  logic [4*DATA_W-1:0]      in_data,
  output logic [3:0]               in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [1:0]               out_lane,
  input  logic                     out_ready
);

  localparam logic [3:0] BurstMax = 4'(BURST_LEN);

  arb_state_e        state_q, state_d;
  lane_idx_t         owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  lane_idx_t         out_lane_q, out_lane_d;

  logic [3:0]        eff_valid;
  logic              slot_free;
  logic              keep;
  logic              grant;
  lane_idx_t         grant_lane;
  lane_idx_t         scan_start;
  logic              pick_found;
  lane_idx_t         pick_idx;
  logic [DATA_W-1:0] lane_data [4];

`ifdef LANE_MASK_EN
  assign eff_valid = in_valid & lane_enable;
`else
  assign eff_valid = in_valid;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_data[i] = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign slot_free  = !out_valid_q || out_ready;
  // owner_q doubles as the round-robin pointer while idle.
  assign scan_start = owner_q + 2'd1;

  rr_pick4 u_pick (
    .req_i   (eff_valid),
    .start_i (scan_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign keep       = (state_q == Own) && eff_valid[owner_q] && (cnt_q < BurstMax);
  assign grant      = slot_free && !reset && (keep || pick_found);
  assign grant_lane = keep ? owner_q : pick_idx;
  assign in_ready   = grant ? lane_onehot(grant_lane) : 4'b0000;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    if (slot_free) begin
      if (grant) begin
        state_d     = Own;
        owner_d     = grant_lane;
        cnt_d       = keep ? cnt_q + 4'd1 : 4'd1;
        out_valid_d = 1'b1;
        out_data_d  = lane_data[grant_lane];
        out_lane_d  = grant_lane;
      end else begin
        state_d     = Idle;
        cnt_d       = 4'd0;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= Idle;
      owner_q     <= 2'd3;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Scoreboard bench for lane_rr_arbiter (BURST_LEN=4, DATA_W=8).
module tb_lane_rr_arbiter;

  localparam int DW = 8;

  typedef struct packed {
    logic [1:0]    lane;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_lane;
  logic            out_ready;
`ifdef LANE_MASK_EN
  logic [3:0]      lane_enable = 4'b1111;
`endif

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lane_rr_arbiter #(
    .DATA_W    (DW),
    .BURST_LEN (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef LANE_MASK_EN
    .lane_enable (lane_enable),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_ready (out_ready)
  );

  function automatic logic [DW-1:0] lane_word(int l);
    return 8'h30 + 8'(l);
  endfunction

  task automatic set_data();
    for (int l = 0; l < 4; l++) in_data[l*DW +: DW] = lane_word(l);
  endtask

  task automatic push_lanes(input int l, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.lane = 2'(l);
      e.data = lane_word(l);
      sb_q.push_back(e);
    end
  endtask

  task automatic flush();
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    set_data();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    set_data();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 8'h00) begin
      n_err++; $display("FAIL reset_out_data got %h want 00", out_data);
    end
    n_cmp++;
    if (out_lane !== 2'd0) begin
      n_err++; $display("FAIL reset_out_lane got %0d want 0", out_lane);
    end
    n_cmp++;
    if (in_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_in_ready got %b want 0000", in_ready);
    end
  endtask

  task automatic test_all_valid();
    exp_t e;
    int   n = 0;
    sb_q.delete();
    for (int k = 0; k < 20; k++) push_lanes((k / 4) % 4, 1);
    @(negedge clk);
    reset = 1'b0;
    while (sb_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL all_valid_throughput cycle %0d out_valid %b want 1", n, out_valid);
      end else begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({out_lane, out_data} !== {e.lane, e.data}) begin
          n_err++;
          $display("FAIL all_valid_beat cycle %0d got lane %0d data %h want lane %0d data %h",
                   n, out_lane, out_data, e.lane, e.data);
        end
      end
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL all_valid_drain left %0d want 0", sb_q.size());
    end
    flush();
  endtask

  task automatic test_single_lane();
    exp_t e;
    int   n = 0;
    int   popped = 0;
    sb_q.delete();
    for (int k = 0; k < 10; k++) begin
      e.lane = 2'd2;
      e.data = (k % 2 == 0) ? 8'hA5 : 8'h5A;
      sb_q.push_back(e);
    end
    in_data[2*DW +: DW] = 8'hA5;
    in_valid = 4'b0100;
    while (sb_q.size() > 0 && n < 30) begin
      @(negedge clk);
      n++;
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL single_lane_bubble cycle %0d out_valid %b want 1", n, out_valid);
      end else begin
        e = sb_q.pop_front();
        popped++;
        n_cmp++;
        if ({out_lane, out_data} !== {e.lane, e.data}) begin
          n_err++;
          $display("FAIL single_lane_beat %0d got lane %0d data %h want lane %0d data %h",
                   popped, out_lane, out_data, e.lane, e.data);
        end
        in_data[2*DW +: DW] = (popped % 2 == 0) ? 8'hA5 : 8'h5A;
      end
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL single_lane_drain left %0d want 0", sb_q.size());
    end
    flush();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n = 0;
    sb_q.delete();
    push_lanes(0, 4);
    push_lanes(1, 4);
    push_lanes(0, 1);
    in_valid = 4'b0011;
    while (sb_q.size() > 0 && n < 40) begin
      @(negedge clk);
      out_ready = (n >= 1 && n <= 3) ? 1'b0 : 1'b1;
      #1;
      if (!out_ready) begin
        n_cmp++;
        if ({out_valid, out_lane, out_data, in_ready} !== {1'b1, 2'd0, lane_word(0), 4'b0000}) begin
          n_err++;
          $display("FAIL stall_hold cycle %0d got v%b lane %0d data %h rdy %b want v1 lane 0 data %h rdy 0000",
                   n, out_valid, out_lane, out_data, in_ready, lane_word(0));
        end
      end else begin
        if (n == 4) begin
          n_cmp++;
          if (in_ready !== 4'b0001) begin
            n_err++; $display("FAIL stall_release_ready got %b want 0001", in_ready);
          end
        end
        if (out_valid === 1'b1) begin
          e = sb_q.pop_front();
          n_cmp++;
          if ({out_lane, out_data} !== {e.lane, e.data}) begin
            n_err++;
            $display("FAIL backpressure_beat cycle %0d got lane %0d data %h want lane %0d data %h",
                     n, out_lane, out_data, e.lane, e.data);
          end
        end
      end
      n++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL backpressure_drain left %0d want 0", sb_q.size());
    end
    flush();
  endtask

  task automatic test_owner_drop();
    exp_t e;
    int   n = 0;
    int   popped = 0;
    sb_q.delete();
    push_lanes(1, 2);
    push_lanes(3, 4);
    push_lanes(0, 4);
    push_lanes(3, 1);
    in_valid = 4'b0010;
    while (sb_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) begin
        e = sb_q.pop_front();
        popped++;
        n_cmp++;
        if ({out_lane, out_data} !== {e.lane, e.data}) begin
          n_err++;
          $display("FAIL owner_drop_beat %0d got lane %0d data %h want lane %0d data %h",
                   popped, out_lane, out_data, e.lane, e.data);
        end
        if (popped == 2) in_valid = 4'b1001;
      end
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL owner_drop_drain left %0d want 0", sb_q.size());
    end
    flush();
  endtask

  task automatic test_reset_mid_burst();
    exp_t e;
    int   n = 0;
    sb_q.delete();
    push_lanes(2, 2);
    in_valid = 4'b0100;
    while (sb_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({out_lane, out_data} !== {e.lane, e.data}) begin
          n_err++;
          $display("FAIL pre_reset_beat got lane %0d data %h want lane %0d data %h",
                   out_lane, out_data, e.lane, e.data);
        end
      end
    end
    #2;
    reset    = 1'b1;
    in_valid = 4'b0110;
    #1;
    n_cmp++;
    if ({out_valid, out_data, out_lane, in_ready} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_async got v%b data %h lane %0d rdy %b want all zero",
               out_valid, out_data, out_lane, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_hold_valid got %b want 0", out_valid);
    end
    reset = 1'b0;
    push_lanes(1, 4);
    push_lanes(2, 1);
    n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL post_reset_valid cycle %0d got %b want 1", n, out_valid);
      end else begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({out_lane, out_data} !== {e.lane, e.data}) begin
          n_err++;
          $display("FAIL post_reset_beat cycle %0d got lane %0d data %h want lane %0d data %h",
                   n, out_lane, out_data, e.lane, e.data);
        end
      end
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL post_reset_drain left %0d want 0", sb_q.size());
    end
    flush();
  endtask

`ifdef LANE_MASK_EN
  task automatic test_lane_mask();
    exp_t e;
    int   n = 0;
    sb_q.delete();
    push_lanes(1, 4);
    push_lanes(3, 4);
    push_lanes(1, 4);
    reset       = 1'b1;
    lane_enable = 4'b1010;
    in_valid    = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    while (sb_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
      n_cmp++;
      if ((in_ready & 4'b0101) !== 4'b0000) begin
        n_err++; $display("FAIL mask_in_ready cycle %0d got %b want lanes 0,2 low", n, in_ready);
      end
      if (out_valid === 1'b1) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({out_lane, out_data} !== {e.lane, e.data}) begin
          n_err++;
          $display("FAIL mask_beat cycle %0d got lane %0d data %h want lane %0d data %h",
                   n, out_lane, out_data, e.lane, e.data);
        end
      end
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL mask_drain left %0d want 0", sb_q.size());
    end
    lane_enable = 4'b1111;
    flush();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_valid();
    test_single_lane();
    test_backpressure();
    test_owner_drop();
    test_reset_mid_burst();
`ifdef LANE_MASK_EN
    test_lane_mask();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lane_rr_arbiter.md
LANE_RR_ARBITER -- requirements
Module: lane_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each lane data word.
REQ-002 SHALL have parameter BURST_LEN, default 4, maximum consecutive beats granted to one lane (legal 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  4  per-lane request; bit i = lane i has a word.
REQ-006 SHALL have port in_data  input  4*DATA_W  lane i word at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port in_ready  output  4  one-hot-or-zero combinational accept; lane i word consumed on an edge where in_valid[i] && in_ready[i].
REQ-008 SHALL have port out_valid  output  1  registered; output word held.
REQ-009 SHALL have port out_data  output  DATA_W  registered accepted word.
REQ-010 SHALL have port out_lane  output  2  registered source lane of out_data.
REQ-011 SHALL have port out_ready  input  1  downstream accept; transfer when out_valid && out_ready.

Function
REQ-012 Output slot free SHALL mean !out_valid || out_ready.
REQ-013 in_ready SHALL be zero when slot not free or no in_valid bit set.
REQ-014 FSM SHALL have states IDLE (no owner) and OWN (owner lane, beat counter cnt 4 bits).
REQ-015 In OWN with slot free: if in_valid[owner] and cnt < BURST_LEN, grant owner, cnt <= cnt+1.
REQ-016 Otherwise (IDLE, owner not valid, or cnt == BURST_LEN) SHALL grant first valid lane scanning owner+1, owner+2, ... mod 4 (IDLE scans from ptr+1, ptr = last owner, reset 3); new owner, cnt <= 1; no bubble cycle.
REQ-017 Re-arbitration SHALL be allowed to reselect the old owner only if no other lane is valid.
REQ-018 No valid lane with slot free SHALL move FSM to IDLE, ptr keeps last owner.
REQ-019 Granted word SHALL appear on out_data/out_lane with out_valid=1 one cycle after the accept edge (latency 1).
REQ-020 Slot free and no grant SHALL clear out_valid; slot not free SHALL hold out_* and FSM/cnt unchanged.
REQ-021 Full throughput SHALL be one word per cycle with out_ready held high.
REQ-022 cnt SHALL saturate at BURST_LEN, never wrap.

Reset
REQ-023 reset high SHALL immediately force out_valid=0, out_data=0, out_lane=0, state=IDLE, cnt=0, ptr=3; in_ready thus 0.
REQ-024 Reset mid-burst SHALL discard held output word; first grant after release SHALL go to lowest valid lane starting at lane 0.

Configuration
REQ-025 Macro LANE_MASK_EN defined SHALL add input lane_enable (4 bits); lane i SHALL be treated as not valid when lane_enable[i]=0, including a current owner (forces re-arbitration next free slot).
REQ-026 LANE_MASK_EN undefined SHALL omit the port; all lanes eligible.

Structure
REQ-027 Shared package lane_arb_pkg SHALL hold NUM_LANES=4, lane index width 2, state encoding IDLE/OWN.
REQ-028 Round-robin search SHALL be sub-module rr_pick4 (4-bit request, 2-bit start, outputs found + 2-bit index), combinational.

Verification
REQ-029 Reset, in_valid=4'b1111, out_ready=1, BURST_LEN=4 -> out_lane 0,0,0,0,1,1,1,1,2,... one word per cycle.
REQ-030 Only lane 2 valid, data 8'hA5 then 8'h5A continuously -> out_lane=2 every cycle, burst limit re-grants lane 2 with no bubble.
REQ-031 out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_lane stable, in_ready=0, cnt unchanged.
REQ-032 Owner lane 1 drops in_valid after 2 beats, lanes 3 and 0 valid -> next out_lane=3, then 0.
REQ-033 Assert reset during burst at cnt=2 -> out_valid=0 same cycle; after release with lanes 1,2 valid first out_lane=1.
REQ-034 LANE_MASK_EN, lane_enable=4'b1010, all valid -> out_lane alternates bursts of 1 and 3 only; lanes 0,2 never in_ready.
